inst_data_mem_arbiter: RTL and testbench
========================================

Name: inst_data_mem_arbiter

Overview:
Sits directly below the instruction fetch controller and shares one pipelined memory slave port between instruction fetch and the CPU load/store unit. Three jobs:
- Arbitrates read/write commands between the two masters.
- Returns the slave's waitrequest to the granted master.
- Tracks outstanding reads so each readdatavalid beat goes back to the master that issued it, in issue order.

Parameters:
p_addr_bits, 32, address width (MEM_ADDR_BITS)
p_data_bits, 32, data width (WORD_BITS)
p_pend_depth, 8, max outstanding reads across both masters
p_pend_log2, 3, log2(p_pend_depth)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_inst_addr  in  p_addr_bits  fetch read address
i_inst_read  in  1  fetch read request
o_inst_waitrequest  out  1  fetch command not accepted this cycle
o_inst_readdata  out  p_data_bits  fetch read data
o_inst_readdatavalid  out  1  fetch read data valid
i_data_addr  in  p_addr_bits  load/store address
i_data_read  in  1  load request
i_data_write  in  1  store request (read and write never both high)
i_data_writedata  in  p_data_bits  store data
i_data_byteenable  in  p_data_bits/8  store byte enables
o_data_waitrequest  out  1  load/store command not accepted
o_data_readdata  out  p_data_bits  load data
o_data_readdatavalid  out  1  load data valid
o_m_addr  out  p_addr_bits  slave address
o_m_read  out  1  slave read
o_m_write  out  1  slave write
o_m_writedata  out  p_data_bits  slave write data
o_m_byteenable  out  p_data_bits/8  slave byte enables (all ones on reads)
o_m_burstcount  out  p_data_bits  constant 1
i_m_waitrequest  in  1  slave stall
i_m_readdata  in  p_data_bits  slave read data
i_m_readdatavalid  in  1  slave read data valid
o_pend_full  out  1  pending-read tracker full

Behaviour:

Requests and grant:
- req_i = i_inst_read & rd_ok; req_d = (i_data_read & rd_ok) | i_data_write.
- rd_ok = !o_pend_full. A read is blocked while the tracker is full, even if a pop occurs the same cycle. Writes are never blocked by the tracker.
- Grant is combinational, zero latency. The command of the granted master drives o_m_* in the same cycle.
- When no master is granted, o_m_read = o_m_write = 0 and the other o_m_* outputs are don't-care.
- Arbitration for an unlocked port:
  - Only one master requests: that master is granted.
  - Both request: round-robin. The master not granted last wins.
  - r_last_id resets to inst, so data wins the first contention.
- Lock: if the granted command sees i_m_waitrequest=1, r_lock is set and r_lock_id holds that master. The grant stays on that master until the command is accepted (i_m_waitrequest=0), even if the other master requests. The master must hold its command stable.
- Accept = granted & (o_m_read|o_m_write) & !i_m_waitrequest. On accept: r_lock clears and r_last_id is updated.

Waitrequest to masters:
- Granted master: o_x_waitrequest = i_m_waitrequest.
- Non-granted master that is requesting: o_x_waitrequest = 1.
- Master with a blocked read (tracker full): o_x_waitrequest = 1.
- Idle master: 0.

Pending-read tracker:
- A 1-bit-wide FIFO of master IDs (0=inst, 1=data), p_pend_depth entries, with r_wr_ptr, r_rd_ptr and r_count (p_pend_log2+1 bits).
- Push on an accepted read; pop on i_m_readdatavalid. Pointers wrap modulo p_pend_depth.
- Push and pop in the same cycle: r_count unchanged, both pointers advance.
- o_pend_full = (r_count == p_pend_depth).
- i_m_readdatavalid with r_count==0 is a protocol error: the beat is dropped, the count does not underflow, and a simulation assertion fires.

Response routing (combinational, zero latency):
- i_m_readdata fans out to both o_inst_readdata and o_data_readdata.
- o_inst_readdatavalid = i_m_readdatavalid & (head==0).
- o_data_readdatavalid = i_m_readdatavalid & (head==1).
- Responses are routed strictly in issue order. A fetch flush upstream does not affect the tracker; stale fetch beats are still delivered to the inst master, which discards them.

Reset:
- Clears pointers and count, r_lock=0, r_last_id=inst.
- All valid and command outputs read 0 in the reset cycle and the cycle after. Reset mid-transaction discards tracker contents.

Test Plan:
1. Inst read 0x100 alone, slave waitrequest=0, data returned 3 cycles later -> o_m_read=1 and o_m_addr=0x100 in the same cycle; r_count goes 1 then 0; o_inst_readdatavalid=1 with the data; o_data_readdatavalid stays 0.
2. Both request reads (inst 0x200, data 0x8000) in the same cycle after reset -> data granted first, inst next cycle; returns D0,D1 routed to data then inst respectively.
3. Data write 0x40 with slave waitrequest=1 for 4 cycles while inst read is also pending -> port locked to data; o_m_* stable for all 4 cycles; o_inst_waitrequest=1; inst granted the cycle after the write is accepted.
4. Issue 8 inst reads with no returns -> o_pend_full=1; 9th read sees o_inst_waitrequest=1 and o_m_read=0; a data write is still accepted; one readdatavalid -> o_pend_full=0 next cycle.
5. Accepted read and readdatavalid in the same cycle at r_count=3 -> r_count stays 3; routing follows the old head.
6. rst asserted with 5 reads pending -> r_count=0, all valids 0; next inst read is routed correctly from an empty tracker.

Source files
------------

// File: rtl/inst_data_mem_arbiter.sv
// Shares one pipelined memory slave port between instruction fetch and the load/store unit.
// Round-robin command arbitration with stall lock, plus an in-order tracker that routes read beats.

module inst_data_mem_arbiter #(
    parameter int p_addr_bits  = 32,
    parameter int p_data_bits  = 32,
    parameter int p_pend_depth = 8,
    parameter int p_pend_log2  = 3
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [p_addr_bits-1:0]     i_inst_addr,
    input  logic                       i_inst_read,
    output logic                       o_inst_waitrequest,
    output logic [p_data_bits-1:0]     o_inst_readdata,
    output logic                       o_inst_readdatavalid,

    input  logic [p_addr_bits-1:0]     i_data_addr,
    input  logic                       i_data_read,
    input  logic                       i_data_write,
    input  logic [p_data_bits-1:0]     i_data_writedata,
    input  logic [p_data_bits/8-1:0]   i_data_byteenable,
    output logic                       o_data_waitrequest,
    output logic [p_data_bits-1:0]     o_data_readdata,
    output logic                       o_data_readdatavalid,

    output logic [p_addr_bits-1:0]     o_m_addr,
    output logic                       o_m_read,
    output logic                       o_m_write,
    output logic [p_data_bits-1:0]     o_m_writedata,
    output logic [p_data_bits/8-1:0]   o_m_byteenable,
    output logic [p_data_bits-1:0]     o_m_burstcount,
    input  logic                       i_m_waitrequest,
    input  logic [p_data_bits-1:0]     i_m_readdata,
    input  logic                       i_m_readdatavalid,

    output logic                       o_pend_full
);

    // Handshake: a command transfers on a cycle where read or write is high and
    // waitrequest is low; with waitrequest high the master must hold the command
    // unchanged. Read data returns one beat per readdatavalid, in issue order.

    localparam logic id_inst = 1'b0;
    localparam logic id_data = 1'b1;

    localparam logic [p_pend_log2:0]   count_full = (p_pend_log2+1)'(p_pend_depth);
    localparam logic [p_pend_log2:0]   count_one  = (p_pend_log2+1)'(1);
    localparam logic [p_pend_log2-1:0] ptr_last   = p_pend_log2'(p_pend_depth - 1);
    localparam logic [p_pend_log2-1:0] ptr_one    = p_pend_log2'(1);

    // Registered state
    logic                    r_rst_q;
    logic [p_pend_depth-1:0] r_ids;
    logic [p_pend_log2-1:0]  r_wr_ptr;
    logic [p_pend_log2-1:0]  r_rd_ptr;
    logic [p_pend_log2:0]    r_count;
    logic                    r_lock;
    logic                    r_lock_id;
    logic                    r_last_id;

    // Combinational control
    logic blk;
    logic rd_ok;
    logic req_i;
    logic req_d;
    logic gnt_any;
    logic gnt_id;
    logic accept;
    logic push;
    logic pop;
    logic head;

    function automatic logic [p_pend_log2-1:0] ptr_next(input logic [p_pend_log2-1:0] p);
        return (p == ptr_last) ? '0 : p + ptr_one;
    endfunction

    // Commands and valids are held off in the reset cycle and the one after it.
    assign blk = rst | r_rst_q;

    assign o_pend_full = (r_count == count_full);
    assign rd_ok       = ~o_pend_full;
    assign req_i       = i_inst_read & rd_ok;
    assign req_d       = (i_data_read & rd_ok) | i_data_write;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = id_inst;
        if (!blk) begin
            if (r_lock) begin
                gnt_id  = r_lock_id;
                gnt_any = (r_lock_id == id_data) ? req_d : req_i;
            end else if (req_i && req_d) begin
                gnt_any = 1'b1;
                gnt_id  = ~r_last_id;
            end else if (req_d) begin
                gnt_any = 1'b1;
                gnt_id  = id_data;
            end else if (req_i) begin
                gnt_any = 1'b1;
                gnt_id  = id_inst;
            end
        end
    end

    always_comb begin
        o_m_addr       = '0;
        o_m_read       = 1'b0;
        o_m_write      = 1'b0;
        o_m_writedata  = '0;
        o_m_byteenable = '1;
        if (gnt_any) begin
            if (gnt_id == id_data) begin
                o_m_addr  = i_data_addr;
                o_m_read  = i_data_read & ~i_data_write;
                o_m_write = i_data_write;
                if (i_data_write) begin
                    o_m_writedata  = i_data_writedata;
                    o_m_byteenable = i_data_byteenable;
                end
            end else begin
                o_m_addr = i_inst_addr;
                o_m_read = 1'b1;
            end
        end
    end

    assign o_m_burstcount = p_data_bits'(1);

    assign accept = gnt_any & (o_m_read | o_m_write) & ~i_m_waitrequest;
    assign push   = accept & o_m_read;
    assign pop    = i_m_readdatavalid & (r_count != '0) & ~blk;
    assign head   = r_ids[r_rd_ptr];

    // A requester that is not granted, including a read blocked by a full tracker, stalls.
    assign o_inst_waitrequest = (gnt_any && gnt_id == id_inst) ? i_m_waitrequest : i_inst_read;
    assign o_data_waitrequest = (gnt_any && gnt_id == id_data) ? i_m_waitrequest
                                                                : (i_data_read | i_data_write);

    assign o_inst_readdata      = i_m_readdata;
    assign o_data_readdata      = i_m_readdata;
    assign o_inst_readdatavalid = pop & (head == id_inst);
    assign o_data_readdatavalid = pop & (head == id_data);

    always_ff @(posedge clk) begin
        r_rst_q <= rst;
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= id_inst;
            r_last_id <= id_inst;
        end else begin
            if (push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (push && !pop) begin
                r_count <= r_count + count_one;
            end else if (pop && !push) begin
                r_count <= r_count - count_one;
            end

            if (accept) begin
                r_lock    <= 1'b0;
                r_last_id <= gnt_id;
            end else if (gnt_any && i_m_waitrequest) begin
                r_lock    <= 1'b1;
                r_lock_id <= gnt_id;
            end
        end
    end

    // ID storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            r_ids[r_wr_ptr] <= gnt_id;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        assert (blk || !i_m_readdatavalid || r_count != '0)
            else $error("inst_data_mem_arbiter: readdatavalid with no read outstanding");
    end
`endif

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// Randomized bench for inst_data_mem_arbiter: two master drivers, a slave model and a
// transaction-level reference that predicts grant, stall and return routing each cycle.

module tb_inst_data_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 8;
    localparam int NCYC  = 1600;

    // Clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] i_inst_addr;
    logic          i_inst_read;
    logic          o_inst_waitrequest;
    logic [DW-1:0] o_inst_readdata;
    logic          o_inst_readdatavalid;
    logic [AW-1:0] i_data_addr;
    logic          i_data_read;
    logic          i_data_write;
    logic [DW-1:0] i_data_writedata;
    logic [BW-1:0] i_data_byteenable;
    logic          o_data_waitrequest;
    logic [DW-1:0] o_data_readdata;
    logic          o_data_readdatavalid;
    logic [AW-1:0] o_m_addr;
    logic          o_m_read;
    logic          o_m_write;
    logic [DW-1:0] o_m_writedata;
    logic [BW-1:0] o_m_byteenable;
    logic [DW-1:0] o_m_burstcount;
    logic          i_m_waitrequest;
    logic [DW-1:0] i_m_readdata;
    logic          i_m_readdatavalid;
    logic          o_pend_full;

    inst_data_mem_arbiter #(
        .p_addr_bits (AW),
        .p_data_bits (DW),
        .p_pend_depth(DEPTH),
        .p_pend_log2 (3)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_inst_addr         (i_inst_addr),
        .i_inst_read         (i_inst_read),
        .o_inst_waitrequest  (o_inst_waitrequest),
        .o_inst_readdata     (o_inst_readdata),
        .o_inst_readdatavalid(o_inst_readdatavalid),
        .i_data_addr         (i_data_addr),
        .i_data_read         (i_data_read),
        .i_data_write        (i_data_write),
        .i_data_writedata    (i_data_writedata),
        .i_data_byteenable   (i_data_byteenable),
        .o_data_waitrequest  (o_data_waitrequest),
        .o_data_readdata     (o_data_readdata),
        .o_data_readdatavalid(o_data_readdatavalid),
        .o_m_addr            (o_m_addr),
        .o_m_read            (o_m_read),
        .o_m_write           (o_m_write),
        .o_m_writedata       (o_m_writedata),
        .o_m_byteenable      (o_m_byteenable),
        .o_m_burstcount      (o_m_burstcount),
        .i_m_waitrequest     (i_m_waitrequest),
        .i_m_readdata        (i_m_readdata),
        .i_m_readdatavalid   (i_m_readdatavalid),
        .o_pend_full         (o_pend_full)
    );

    // Scoreboard: issuing master of every outstanding read, and the data the slave will return
    logic [0:0]    exp_q[$];
    logic [DW-1:0] slv_q[$];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Master and model state
    bit            inst_pend, data_pend, data_wr;
    logic [AW-1:0] inst_addr_v, data_addr_v;
    logic [DW-1:0] data_wdata_v;
    logic [BW-1:0] data_be_v;
    bit            prev_rst, lock_v, lock_who, last_who;
    bit            rv;
    int            req_pct, wait_pct, ret_pct;

    // Driver: masters hold a command until it is accepted
    task automatic drive_cycle(input int cyc);
        if (rst || prev_rst) begin
            inst_pend = 0;
            data_pend = 0;
        end else begin
            if (cyc == 3) begin
                inst_pend = 1; inst_addr_v = 32'h200;
                data_pend = 1; data_wr = 0; data_addr_v = 32'h8000;
            end
            if (!inst_pend && $urandom_range(0, 99) < req_pct) begin
                inst_pend   = 1;
                inst_addr_v = $urandom;
            end
            if (!data_pend && $urandom_range(0, 99) < req_pct) begin
                data_pend    = 1;
                data_wr      = ($urandom_range(0, 2) == 0);
                data_addr_v  = $urandom;
                data_wdata_v = $urandom;
                data_be_v    = BW'($urandom_range(0, (1 << BW) - 1));
            end
        end
        i_inst_read       = inst_pend;
        i_inst_addr       = inst_addr_v;
        i_data_read       = data_pend && !data_wr;
        i_data_write      = data_pend && data_wr;
        i_data_addr       = data_addr_v;
        i_data_writedata  = data_wdata_v;
        i_data_byteenable = data_be_v;
        i_m_waitrequest   = ($urandom_range(0, 99) < wait_pct);
        rv = !prev_rst && (slv_q.size() > 0) && ($urandom_range(0, 99) < ret_pct);
        i_m_readdatavalid = rv;
        i_m_readdata      = rv ? slv_q[0] : $urandom;
    endtask

    initial begin
        bit blk, full, ri, rd, e_gnt, who, e_rd, e_wr, e_iw, e_dw, e_iv, e_dv;
        rst = 1'b1;
        prev_rst = 0; lock_v = 0; lock_who = 0; last_who = 0;
        inst_pend = 0; data_pend = 0; data_wr = 0;
        inst_addr_v = '0; data_addr_v = '0; data_wdata_v = '0; data_be_v = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            rst = (cyc < 2) || (cyc == 1000) || (cyc == 1001);
            if (cyc >= 600 && cyc < 1000) begin
                req_pct = 85; wait_pct = 15; ret_pct = 4;
            end else begin
                req_pct = 70; wait_pct = 30; ret_pct = 50;
            end
            drive_cycle(cyc);
            #3;

            // Reference: expected grant from the arbitration rules
            blk   = rst || prev_rst;
            full  = (exp_q.size() == DEPTH);
            ri    = i_inst_read && !full;
            rd    = (i_data_read && !full) || i_data_write;
            e_gnt = 0;
            who   = 0;
            if (!blk) begin
                if (lock_v) begin
                    who = lock_who; e_gnt = who ? rd : ri;
                end else if (ri && rd) begin
                    who = !last_who; e_gnt = 1;
                end else if (rd || ri) begin
                    who = rd; e_gnt = 1;
                end
            end
            e_rd = e_gnt && (who ? i_data_read : 1'b1);
            e_wr = e_gnt && who && i_data_write;
            e_iw = (e_gnt && !who) ? i_m_waitrequest : i_inst_read;
            e_dw = (e_gnt && who)  ? i_m_waitrequest : (i_data_read || i_data_write);
            e_iv = rv && !blk && exp_q.size() > 0 && exp_q[0] == 1'b0;
            e_dv = rv && !blk && exp_q.size() > 0 && exp_q[0] == 1'b1;

            if (cyc > 0) begin
                check("m_read", o_m_read, e_rd);
                check("m_write", o_m_write, e_wr);
                check("inst_wait", o_inst_waitrequest, e_iw);
                check("data_wait", o_data_waitrequest, e_dw);
                check("pend_full", o_pend_full, full);
                check("inst_rdv", o_inst_readdatavalid, e_iv);
                check("data_rdv", o_data_readdatavalid, e_dv);
                if (e_gnt) check("m_addr", o_m_addr, who ? i_data_addr : i_inst_addr);
                if (e_rd) check("m_be_rd", o_m_byteenable, {BW{1'b1}});
                if (e_wr) begin
                    check("m_wdata", o_m_writedata, i_data_writedata);
                    check("m_be_wr", o_m_byteenable, i_data_byteenable);
                end
                if (e_iv) check("inst_rdata", o_inst_readdata, slv_q[0]);
                if (e_dv) check("data_rdata", o_data_readdata, slv_q[0]);
                if (cyc == 5) check("burstcount", o_m_burstcount, 1);
            end

            @(posedge clk);
            if (rst) begin
                exp_q.delete(); slv_q.delete();
                lock_v = 0; last_who = 0; prev_rst = 1;
                inst_pend = 0; data_pend = 0;
            end else begin
                prev_rst = 0;
                if (e_iv || e_dv) begin
                    void'(exp_q.pop_front());
                    void'(slv_q.pop_front());
                end
                if (e_gnt && !i_m_waitrequest) begin
                    if (e_rd) begin
                        exp_q.push_back(who);
                        slv_q.push_back($urandom);
                    end
                    lock_v = 0; last_who = who;
                    if (who) data_pend = 0; else inst_pend = 0;
                end else if (e_gnt) begin
                    lock_v = 1; lock_who = who;
                end
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
